// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - run sequencer with core reset hold and probe trace buffer (option: TRACE_CAPTURE_TIMESTAMP_EN)
module trace_capture #(
    parameter int DATA_W     = 32,
    parameter int CH         = 3,
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 6,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CNT_W-1:0]          max_cycles,
    input  logic                      wrap_mode,
    input  logic [CH*DATA_W-1:0]      probe,
    input  logic                      probe_valid,
    input  logic                      rd_en,
    output logic                      core_reset,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic [CH*DATA_W-1:0]      rd_data,
    output logic                      rd_valid
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0]          rd_stamp
`endif
);

    localparam int W     = CH * DATA_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int HC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]    max_q, max_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;
    logic                core_reset_q, core_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [W-1:0]        rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [W-1:0]        mem_q [DEPTH];

    logic                capture;
    logic                clear;
    logic                do_pop;
    logic                push_new;
    logic                wr_en;
    logic                full_w;

    assign full_w = (level_q == LVL_W'(DEPTH));

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    logic [CNT_W-1:0]    stamp_mem_q [DEPTH];
    logic [CNT_W-1:0]    rd_stamp_q, rd_stamp_d;
`endif

    // Next-state: run sequencing first, then buffer pop-before-push, then start-time clear
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        max_d        = max_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        capture      = 1'b0;
        clear        = 1'b0;
        push_new     = 1'b0;
        wr_en        = 1'b0;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
        rd_stamp_d   = rd_stamp_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = HOLD;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    max_d       = max_cycles;
                    clear       = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = DONE;
                end else if (hold_cnt_q == HC_W'(RST_CYCLES - 1)) begin
                    state_d = (max_q == '0) ? DONE : RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            RUN: begin
                // abort freezes the counter and suppresses capture in its own cycle
                if (abort) begin
                    state_d = DONE;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    capture     = probe_valid;
                    if (cycle_cnt_q == max_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        do_pop = rd_en && (level_q != '0);
        if (do_pop) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
            rd_stamp_d = stamp_mem_q[rd_ptr_q];
`endif
        end

        if (capture) begin
            if (!full_w || do_pop) begin
                push_new = 1'b1;
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else if (wrap_mode) begin
                // full: write lands on the oldest slot, so both pointers advance
                wr_en      = 1'b1;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                overflow_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (push_new && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_new && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end

        core_reset_d = (state_d == HOLD);
        busy_d       = (state_d == HOLD) || (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    // Control, pointer and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            max_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
            rd_stamp_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            max_q        <= max_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
            rd_stamp_q   <= rd_stamp_d;
`endif
        end
    end

    // Trace storage; contents are don't-care once level is cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= probe;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
            stamp_mem_q[wr_ptr_q] <= cycle_cnt_q;
`endif
        end
    end

    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign level      = level_q;
    assign full       = full_w;
    assign empty      = (level_q == '0);
    assign overflow   = overflow_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    assign rd_stamp   = rd_stamp_q;
`endif

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DATA_W, default 32: width of one probe channel.
REQ-002 Parameter CH, default 3: number of probe channels captured per entry.
REQ-003 Parameter DEPTH, default 16: trace buffer entries; power of two, >= 2.
REQ-004 Parameter RST_CYCLES, default 6: cycles core_reset is held per run; >= 1.
REQ-005 Parameter CNT_W, default 16: width of the cycle counter and the run length.
REQ-006 clk  in  1  single clock; all state on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low; asserts immediately, releases synchronously to clk.
REQ-008 start  in  1  one-cycle pulse that begins a run.
REQ-009 abort  in  1  ends the run early.
REQ-010 max_cycles  in  CNT_W  RUN-phase length in cycles, sampled on the accepted start.
REQ-011 wrap_mode  in  1  1 = overwrite oldest entry when full; 0 = drop new samples when full.
REQ-012 probe  in  CH*DATA_W  channel k is at bits [k*DATA_W +: DATA_W].
REQ-013 probe_valid  in  1  the probe word is valid this cycle.
REQ-014 rd_en  in  1  pop request for the oldest entry.
REQ-015 core_reset  out  1  active-high reset to the core under test.
REQ-016 busy, done  out  1 each  run in progress; run finished.
REQ-017 cycle_cnt  out  CNT_W  RUN cycles elapsed.
REQ-018 level  out  $clog2(DEPTH)+1  entries held; full, empty, overflow  out  1 each.
REQ-019 rd_data  out  CH*DATA_W; rd_valid  out  1.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, HOLD, RUN, DONE.
REQ-021 start in IDLE or DONE SHALL do all of: go to HOLD, clear buffer, overflow and cycle_cnt, latch max_cycles; start in HOLD/RUN SHALL be ignored.
REQ-022 HOLD SHALL drive core_reset=1 for exactly RST_CYCLES cycles, then go to RUN; busy=1 in HOLD and RUN only.
REQ-023 RUN SHALL increment cycle_cnt by 1 every cycle and go to DONE in the cycle after cycle_cnt reaches latched max_cycles-1.
REQ-024 If max_cycles=0, HOLD SHALL go directly to DONE and capture nothing.
REQ-025 abort in HOLD or RUN SHALL go to DONE next cycle, with core_reset=0 and cycle_cnt frozen; abort in IDLE/DONE has no effect.
REQ-026 done SHALL be 1 only in DONE; cycle_cnt holds its value in DONE.
REQ-027 Capture SHALL occur only in RUN when probe_valid=1; the whole CH*DATA_W word is written as one entry.
REQ-028 Write when full with wrap_mode=1 SHALL overwrite the oldest entry; level stays DEPTH and overflow is set.
REQ-029 Write when full with wrap_mode=0 SHALL drop the sample; overflow is set.
REQ-030 overflow SHALL be sticky until reset or the next accepted start.
REQ-031 rd_en while non-empty SHALL present the oldest entry on rd_data with rd_valid=1 the next cycle; rd_en while empty SHALL be ignored (rd_valid=0).
REQ-032 A read and a write in the same cycle while full SHALL pop, then push; level stays DEPTH and overflow is not set.
REQ-033 Reads SHALL be legal in every state; rd_data holds its last value when rd_valid=0.
REQ-034 full=(level==DEPTH) and empty=(level==0); pointers wrap modulo DEPTH.

Reset
REQ-035 On reset low: state IDLE, core_reset=1, busy=0, done=0, cycle_cnt=0, level=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0.
REQ-036 core_reset SHALL drop to 0 in the first cycle after reset release while in IDLE.
REQ-037 Reset mid-run SHALL discard all buffered entries.

Configuration
REQ-038 With TRACE_CAPTURE_TIMESTAMP_EN defined: each entry also stores cycle_cnt at capture, output on an extra port rd_stamp (CNT_W) aligned with rd_data.
REQ-039 Without TRACE_CAPTURE_TIMESTAMP_EN: there is no rd_stamp port and no stamp storage.

Verification
REQ-040 Test 1: start, max_cycles=10, probe_valid always 1 -> core_reset=1 for 6 cycles; done after 10 RUN cycles; level=10; 10 pops return the probe values in order.
REQ-041 Test 2: DEPTH=16, wrap_mode=1, 20 valid samples 0..19 -> level=16, overflow=1; pops return 4..19.
REQ-042 Test 3: same stimulus, wrap_mode=0 -> pops return 0..15; overflow=1.
REQ-043 Test 4: abort at RUN cycle 3 -> done next cycle; cycle_cnt=3 or 4, frozen; no further captures.
REQ-044 Test 5: full buffer, simultaneous rd_en and write -> level stays 16; overflow stays 0.
REQ-045 Test 6: reset low mid-RUN -> all outputs reach their reset values asynchronously; start with max_cycles=0 after release -> done after HOLD; empty=1.
